uart_rx: RTL
============

Name: uart_rx

Overview:
- Receive side of the UART link; pairs with the uart_tx transmitter.
- Samples the asynchronous serial line, detects and validates the start bit, and shifts in DATA_BITS data bits LSB first at mid-bit.
- Checks the stop bit, then presents the byte with a one-cycle valid strobe.
- Sits between the pad-side serial input and the consumer logic, e.g. a FIFO or command decoder.

Parameters:
- CLKS_PER_BIT, 16, i_rx_clk cycles per bit period; must be >= 4.
- DATA_BITS, 8, data bits per frame; legal range 5..8.

Ports:
- i_rx_clk  input  1  receiver clock.
- i_rx_rst  input  1  asynchronous, active-high reset.
- i_rx_serial  input  1  serial line; idle high; asynchronous to i_rx_clk.
- o_rx_data  output  DATA_BITS  last good received word; holds until the next good frame.
- o_rx_data_valid  output  1  one-cycle pulse when o_rx_data updates.
- o_rx_frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
- o_rx_busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, active-high):
  - State = IDLE. Bit counter and clock counter = 0. Shift register = 0.
  - o_rx_data = 0, o_rx_data_valid = 0, o_rx_frame_err = 0, o_rx_busy = 0.
  - Both synchronizer flops preset to 1, so no false start is seen after reset.
  - Reset asserted mid-frame aborts the frame; no strobe is produced.
- Input path: 2-flop synchronizer. All decisions use the synchronized line (rx_s), 2 cycles behind the pin.
- Clock counter: counts 0..CLKS_PER_BIT-1 and clears on every state transition.
- IDLE:
  - Counters held at 0.
  - rx_s == 0 -> START.
- START:
  - At clk_cnt == (CLKS_PER_BIT-1)/2 (mid start bit), sample rx_s.
  - rx_s == 0 -> DATA, bit_idx = 0.
  - rx_s == 1 -> IDLE (glitch rejected, no strobe).
- DATA:
  - At clk_cnt == CLKS_PER_BIT-1, shift_reg[bit_idx] <= rx_s and clk_cnt <= 0.
  - When bit_idx == DATA_BITS-1 at that sample -> STOP (or PARITY when enabled); otherwise bit_idx++.
- STOP:
  - At clk_cnt == CLKS_PER_BIT-1, sample rx_s.
  - rx_s == 1 and no parity error: o_rx_data <= shift_reg, o_rx_data_valid = 1 for one cycle.
  - rx_s == 0: o_rx_frame_err = 1 for one cycle; o_rx_data unchanged.
  - Either case -> IDLE on the next edge.
- Re-arm timing: IDLE is re-entered at mid stop bit, so a start bit immediately following the stop bit is caught.
- Break condition (line held low): produces a frame error, then a new START. Each successive frame errors until the line goes high.
- Latency: valid pulse asserts 2 + (CLKS_PER_BIT-1)/2 + (DATA_BITS+1)*CLKS_PER_BIT (+CLKS_PER_BIT with parity) +1 cycles after the falling edge at the pin.
- Simultaneous events: none possible; there is a single input and no backpressure. The consumer must take o_rx_data within one frame time.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state after DATA.
  - At mid parity bit, the sampled bit is compared with the XOR of the data bits (even parity).
  - Adds output port o_rx_parity_err (1 bit), pulsed in the STOP-sample cycle on mismatch.
  - On mismatch, o_rx_data_valid is suppressed and o_rx_data is not updated.
  - If both stop and parity fail, both error strobes fire.
- Undefined: no PARITY state and no o_rx_parity_err port; frame is start + DATA_BITS + stop.

Decomposition:
- Package uart_pkg:
  - State encoding constants: IDLE, START, DATA, PARITY, STOP.
  - Constants DEFAULT_CLKS_PER_BIT and DEFAULT_DATA_BITS, shared with uart_tx.
- Sub-module uart_sync2: 2-flop synchronizer with reset-preset value parameter; reusable by other clock-crossing inputs.
- Counters, shift register and FSM live in uart_rx.

Test Plan (CLKS_PER_BIT=4, DATA_BITS=8):
- Reset mid-frame:
  - Stimulus: i_rx_rst=1 while in DATA.
  - Response: o_rx_busy=0 immediately; no strobe; a following clean frame of 0x5A gives o_rx_data=0x5A.
- Nominal frame:
  - Stimulus: drive 0xA3 (start, 1,1,0,0,0,1,0,1, stop) at 4 clks/bit.
  - Response: exactly one o_rx_data_valid pulse; o_rx_data=0xA3; o_rx_frame_err=0; o_rx_busy low after.
- Back-to-back frames:
  - Stimulus: 0x00 then 0xFF with no idle gap.
  - Response: two valid pulses, data 0x00 then 0xFF.
- Glitch rejection:
  - Stimulus: 1-cycle low pulse on the idle line.
  - Response: FSM returns to IDLE; no valid, no error.
- Framing error:
  - Stimulus: 0x3C with stop bit driven 0.
  - Response: o_rx_frame_err pulses once; o_rx_data keeps its previous value; no valid pulse.
- Parity (UART_RX_PARITY_EN defined):
  - Stimulus: 0x07 with parity bit 0 (wrong).
  - Response: o_rx_parity_err pulses once; no valid pulse.
  - Stimulus: same data with parity bit 1.
  - Response: valid pulse; o_rx_data=0x07.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding and default link
// parameters common to uart_rx and uart_tx.
package uart_pkg;

  // Default bit period in receiver clocks, and default word width.
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 16;
  localparam int unsigned DEFAULT_DATA_BITS    = 8;

  // Receiver frame-tracking states; PARITY is only reachable when parity
  // checking is compiled in.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // Even-parity bit for an 8-bit word (XOR of all bits). Narrower words
  // are zero-extended by the caller, which does not change the result.
  function automatic logic even_parity(input logic [7:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input. RST_VAL sets the
// value both stages take on reset, so the synchronized output starts at a
// known, benign level (e.g. idle-high for a serial line).
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back capture stages; the first may go metastable.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizes the serial line, validates the start bit at
// mid-bit, shifts DATA_BITS data bits in LSB first, checks the stop bit
// and presents the word with a one-cycle valid strobe.
// Optional even-parity checking is compiled in with `define UART_RX_PARITY_EN,
// which adds a PARITY state and the o_rx_parity_err port.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = DEFAULT_DATA_BITS
) (
  input  logic                 i_rx_clk,
  input  logic                 i_rx_rst,
  input  logic                 i_rx_serial,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_data_valid,
  output logic                 o_rx_frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                 o_rx_parity_err,
`endif
  output logic                 o_rx_busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);

  // Mid start bit, then full bit periods land each later sample mid-bit.
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic                 rx_s;

  uart_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q,   cnt_d;
  logic [IDX_W-1:0]     idx_q,   idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q,  data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q,  ferr_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q, par_bad_d;
  logic                 perr_q,    perr_d;
  logic [7:0]           shift_ext;

  assign shift_ext = 8'(shift_q);
`endif

  // Line is idle-high, so preset the synchronizer to 1 to avoid a false
  // start bit immediately after reset.
  uart_sync2 #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk_i (i_rx_clk),
    .rst_i (i_rx_rst),
    .d_i   (i_rx_serial),
    .q_o   (rx_s)
  );

  // State, counters, shift register and output strobes.
  always_ff @(posedge i_rx_clk or posedge i_rx_rst) begin
    if (i_rx_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
`endif
    end
  end

  // Next-state, sampling and strobe generation. The clock counter clears on
  // every state change, so each state times its sample from its own entry.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    idx_d     = idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = 1'b0;
`endif
        if (!rx_s) begin
          state_d = START;
        end
      end

      START: begin
        if (cnt_q == CNT_MID) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            // Low pulse shorter than half a bit: treat as noise.
            state_d = IDLE;
          end
        end
      end

      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          for (int unsigned i = 0; i < DATA_BITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
              shift_d[i] = rx_s;
            end
          end
          if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          par_bad_d = rx_s ^ even_parity(shift_ext);
          state_d   = STOP;
        end
      end
`endif

      STOP: begin
        // Returning to IDLE at mid stop bit leaves half a bit of margin to
        // catch a start bit that follows immediately.
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
`ifdef UART_RX_PARITY_EN
          if (rx_s && !par_bad_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end
          perr_d = par_bad_q;
`else
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end
`endif
          ferr_d = ~rx_s;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign o_rx_data       = data_q;
  assign o_rx_data_valid = valid_q;
  assign o_rx_frame_err  = ferr_q;
  assign o_rx_busy       = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign o_rx_parity_err = perr_q;
`endif

endmodule
